// File: rtl/core_sequencer_pkg.sv
// Shared definitions for the power-up / reset sequencer: state encoding,
// default timing constants and the running-state helper.
package core_sequencer_pkg;

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        HOLD      = 3'd1,
        CLK_RUN   = 3'd2,
        CORE_REL  = 3'd3,
        RUN       = 3'd4,
        SOFT_RST  = 3'd5
    } seq_state_t;

    localparam int CNT_W               = 16;
    localparam int DEF_HOLD_CYCLES     = 256;
    localparam int DEF_GAP_CYCLES      = 16;
    localparam int DEF_DEBOUNCE_CYCLES = 65536;

    // States in which the clock-enable phase counter advances
    function automatic logic is_running(seq_state_t s);
        return (s == CLK_RUN) || (s == CORE_REL) || (s == RUN) || (s == SOFT_RST);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Synchronises the bouncy active-low reset button and reports a press once it
// has been seen low for the full debounce interval without interruption.
module btn_debounce
    import core_sequencer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_btn_n,
    output logic o_press
);

    // Intervals beyond the counter range saturate at its maximum
    localparam logic [CNT_W-1:0] LIMIT =
        (DEBOUNCE_CYCLES > 65535) ? 16'hFFFF : 16'(DEBOUNCE_CYCLES);

    logic             r_btn_s1;
    logic             r_btn_s2;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_btn_s1 <= 1'b1;
            r_btn_s2 <= 1'b1;
            r_cnt    <= '0;
        end else begin
            r_btn_s1 <= i_btn_n;
            r_btn_s2 <= r_btn_s1;
            if (r_btn_s2) begin
                r_cnt <= '0;
            end else if (r_cnt != LIMIT) begin
                r_cnt <= r_cnt + 16'd1;
            end
        end
    end

    assign o_press = (r_cnt == LIMIT);

endmodule

// File: rtl/core_sequencer.sv
// Power-up and soft-reset sequencer: waits for PLL lock, starts the divided
// clock enables, then releases video, core and audio resets in turn.
module core_sequencer
    import core_sequencer_pkg::*;
#(
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int GAP_CYCLES      = DEF_GAP_CYCLES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic       clk_48M,
    input  logic       reset,
    input  logic       pll_lckd,
    input  logic       btn_nreset,
    input  logic       key_reset,
    output logic       ena_24,
    output logic       ena_12,
    output logic       ena_6,
    output logic       video_rst,
    output logic       core_rst,
    output logic       audio_rst,
    output logic [2:0] seq_state
);

    localparam logic [CNT_W-1:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = 16'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_FULL = 16'(HOLD_CYCLES);

    logic             r_lock_s1;
    logic             r_lock_s2;
    seq_state_t       r_state;
    seq_state_t       w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_next_cnt;
    logic [2:0]       r_ph;
    logic [2:0]       w_next_ph;
    logic             r_video_rst;
    logic             r_core_rst;
    logic             r_audio_rst;
    logic             w_video_rst_d;
    logic             w_core_rst_d;
    logic             w_audio_rst_d;
    logic             w_running;
    logic             w_btn_press;
    logic             w_rst_req;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .i_clk   (clk_48M),
        .i_reset (reset),
        .i_btn_n (btn_nreset),
        .o_press (w_btn_press)
    );

    assign w_rst_req = w_btn_press | key_reset;

    always_ff @(posedge clk_48M or posedge reset) begin
        if (reset) begin
            r_lock_s1 <= 1'b0;
            r_lock_s2 <= 1'b0;
        end else begin
            r_lock_s1 <= pll_lckd;
            r_lock_s2 <= r_lock_s1;
        end
    end

    always_ff @(posedge clk_48M or posedge reset) begin
        if (reset) begin
            r_state     <= WAIT_LOCK;
            r_cnt       <= '0;
            r_ph        <= '0;
            r_video_rst <= 1'b1;
            r_core_rst  <= 1'b1;
            r_audio_rst <= 1'b1;
        end else begin
            r_state     <= w_next_state;
            r_cnt       <= w_next_cnt;
            r_ph        <= w_next_ph;
            r_video_rst <= w_video_rst_d;
            r_core_rst  <= w_core_rst_d;
            r_audio_rst <= w_audio_rst_d;
        end
    end

    // SOFT_RST only starts counting once the request has gone away
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt + 16'd1;
        if (!r_lock_s2) begin
            w_next_state = WAIT_LOCK;
        end else begin
            case (r_state)
                WAIT_LOCK: w_next_state = HOLD;
                HOLD:      if (r_cnt == HOLD_LAST) w_next_state = CLK_RUN;
                CLK_RUN: begin
                    if (w_rst_req)                w_next_state = SOFT_RST;
                    else if (r_cnt == GAP_LAST)   w_next_state = CORE_REL;
                end
                CORE_REL: begin
                    if (w_rst_req)                w_next_state = SOFT_RST;
                    else if (r_cnt == GAP_LAST)   w_next_state = RUN;
                end
                RUN:       if (w_rst_req) w_next_state = SOFT_RST;
                SOFT_RST: begin
                    if (w_rst_req)                w_next_cnt   = '0;
                    else if (r_cnt == HOLD_FULL)  w_next_state = CORE_REL;
                end
                default:   w_next_state = WAIT_LOCK;
            endcase
        end
        if ((w_next_state != r_state) || (w_next_state == WAIT_LOCK) ||
            (w_next_state == RUN)) begin
            w_next_cnt = '0;
        end
    end

    // Reset outputs are registered from the next state so they switch on the transition edge
    always_comb begin
        w_video_rst_d = (w_next_state == WAIT_LOCK) || (w_next_state == HOLD);
        w_core_rst_d  = !((w_next_state == CORE_REL) || (w_next_state == RUN));
        w_audio_rst_d = (w_next_state != RUN);
        w_running     = is_running(r_state);
        w_next_ph     = (w_running && is_running(w_next_state)) ? r_ph + 3'd1 : 3'd0;
        ena_24        = w_running & r_ph[0];
        ena_12        = w_running & (r_ph[1:0] == 2'd3);
        ena_6         = w_running & (r_ph == 3'd7);
    end

    assign video_rst = r_video_rst;
    assign core_rst  = r_core_rst;
    assign audio_rst = r_audio_rst;
    assign seq_state = r_state;

endmodule
